drum_div_seq: RTL and testbench

- Iterative approximate unsigned divider in the DRUM style: the inverse operation of the team's DRUM approximate multipliers.
- Each operand is reduced to a K-bit mantissa and an exponent using leading-one detection, with the mantissa LSB forced to 1 for unbiasing.
- A restoring division of the mantissas produces one quotient bit per cycle; the result is then rescaled by the exponent difference.
- Used in accelerator datapaths beside DRUM6_16 multipliers; valid/ready handshake on both sides.

---
 rtl/drum_div_pkg.sv | 19 +
 rtl/drum_div_seq_if.sv | 23 ++
 rtl/drum_div_norm.sv | 32 +++
 rtl/drum_div_seq.sv | 147 ++++++++++++++
 tb/tb_drum_div_seq.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/drum_div_pkg.sv
// Shared types and constants for the DRUM-style iterative approximate divider.
package drum_div_pkg;

  localparam int W_DEF   = 16;
  localparam int K_DEF   = 6;
  localparam int F_DEF   = 12;
  localparam int LATENCY = K_DEF + F_DEF + 2;
  // Signed exponent width: holds +/-(W-K) as a difference of two exponents.
  localparam int EXP_W   = $clog2(W_DEF) + 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DIV,
    FIN,
    DONE
  } state_t;

endpackage

// File: rtl/drum_div_seq_if.sv
// Valid/ready operand and result channel of the DRUM approximate divider.
interface drum_div_seq_if #(
  parameter int W = drum_div_pkg::W_DEF
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] q;
  logic         dbz;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, q, dbz
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, q, dbz
  );
endinterface

// File: rtl/drum_div_norm.sv
// Leading-one detect and K-bit mantissa/exponent extraction for one operand.
module drum_div_norm
  import drum_div_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int K = K_DEF
) (
  input  logic [W-1:0]     x,
  output logic [K-1:0]     mx,
  output logic [EXP_W-1:0] px
);
  localparam int IW = $clog2(W);

  logic [IW-1:0] kx;

  always_comb begin
    kx = '0;
    for (int i = 0; i < W; i++) begin
      if (x[i]) kx = IW'(i);
    end
    mx = x[K-1:0];
    px = '0;
    if (int'(kx) >= K) begin
      // Keep the K-1 bits below and including the leading one, LSB forced to 1.
      mx[0] = 1'b1;
      for (int j = 1; j < K; j++) begin
        mx[j] = x[IW'(int'(kx) - K + 1 + j)];
      end
      px = EXP_W'(kx) - EXP_W'(K - 1);
    end
  end
endmodule

// File: rtl/drum_div_seq.sv
// Iterative DRUM approximate unsigned divider, one quotient bit per cycle.
// Optional round-half-up of the rescaled result: define DRUM_DIV_ROUND_EN.
module drum_div_seq
  import drum_div_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int K = K_DEF,
  parameter int F = F_DEF
) (
  input logic           clk,
  input logic           rst_n,
  drum_div_seq_if.slave bus
);
  localparam int QW   = K + F;
  localparam int RW   = F + W + 1;
  localparam int CW   = $clog2(K + F) + 1;
  localparam int SH_W = $clog2(F + W) + 1;

  state_t                state_reg;
  logic                  in_ready_reg;
  logic                  out_valid_reg;
  logic [W-1:0]          q_reg;
  logic                  dbz_reg;
  logic [W-1:0]          opd_reg [2];
  logic [K-1:0]          mb_reg;
  logic [EXP_W-1:0]      pa_reg;
  logic [EXP_W-1:0]      pb_reg;
  logic [K-1:0]          rem_reg;
  logic [QW-1:0]         nq_reg;
  logic [CW-1:0]         cnt_reg;

  logic [K-1:0]          mant [2];
  logic [EXP_W-1:0]      expo [2];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_norm
      drum_div_norm #(.W(W), .K(K)) u_norm (
        .x  (opd_reg[gi]),
        .mx (mant[gi]),
        .px (expo[gi])
      );
    end
  endgenerate

  // One restoring step: shift the next numerator bit into the remainder.
  logic [K:0]   trial;
  logic         ge;
  logic [K-1:0] rem_next;

  always_comb begin
    trial    = {rem_reg, nq_reg[QW-1]};
    ge       = (trial >= {1'b0, mb_reg});
    rem_next = ge ? (trial[K-1:0] - mb_reg) : trial[K-1:0];
  end

  logic signed [EXP_W-1:0] s_exp;
  logic [EXP_W-1:0]        lsh;
  logic [EXP_W-1:0]        rsh_x;
  logic [SH_W-1:0]         shamt;
  logic [RW-1:0]           ext;
  logic [RW-1:0]           res;
  logic                    sat;

  always_comb begin
    s_exp = $signed(pa_reg) - $signed(pb_reg);
    lsh   = s_exp[EXP_W-1] ? '0 : s_exp;
    rsh_x = s_exp[EXP_W-1] ? -s_exp : '0;
    shamt = SH_W'(F) + SH_W'(rsh_x);
    ext   = RW'(nq_reg) << lsh;
`ifdef DRUM_DIV_ROUND_EN
    ext   = ext + (RW'(1) << (shamt - 1'b1));
`else
`endif
    res   = ext >> shamt;
    sat   = |res[RW-1:W];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      q_reg         <= '0;
      dbz_reg       <= 1'b0;
      opd_reg[0]    <= '0;
      opd_reg[1]    <= '0;
      mb_reg        <= '0;
      pa_reg        <= '0;
      pb_reg        <= '0;
      rem_reg       <= '0;
      nq_reg        <= '0;
      cnt_reg       <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.in_valid && in_ready_reg) begin
            opd_reg[0]   <= bus.a;
            opd_reg[1]   <= bus.b;
            in_ready_reg <= 1'b0;
            state_reg    <= LOAD;
          end
        end
        LOAD: begin
          nq_reg    <= {mant[0], {F{1'b0}}};
          mb_reg    <= mant[1];
          pa_reg    <= expo[0];
          pb_reg    <= expo[1];
          rem_reg   <= '0;
          cnt_reg   <= '0;
          state_reg <= DIV;
        end
        DIV: begin
          rem_reg <= rem_next;
          nq_reg  <= {nq_reg[QW-2:0], ge};
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == CW'(K + F - 1)) state_reg <= FIN;
        end
        FIN: begin
          // Divide-by-zero overrides whatever the datapath produced.
          if (opd_reg[1] == '0) begin
            q_reg   <= '1;
            dbz_reg <= 1'b1;
          end else begin
            q_reg   <= sat ? '1 : res[W-1:0];
            dbz_reg <= 1'b0;
          end
          out_valid_reg <= 1'b1;
          state_reg     <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.q         = q_reg;
  assign bus.dbz       = dbz_reg;
endmodule

// File: tb/tb_drum_div_seq.sv
// Scoreboard bench for drum_div_seq: expected results queued at accept, compared on out_valid.
module tb_drum_div_seq;
  import drum_div_pkg::*;

  localparam int W = 16;
  localparam int K = 6;
  localparam int F = 12;

  typedef struct {
    logic [W-1:0] q;
    logic         dbz;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb_q[$];

  drum_div_seq_if #(.W(W)) bus ();

  drum_div_seq #(.W(W), .K(K), .F(F)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, expv);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  function automatic void norm_model(input logic [W-1:0] x, output longint m, output int p);
    int k = -1;
    for (int i = 0; i < W; i++) if (x[i]) k = i;
    if (k < K) begin
      m = x;
      p = 0;
    end else begin
      m = ((longint'(x) >> (k - K + 1)) % (1 << K)) | 1;
      p = k - K + 1;
    end
  endfunction

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   r;
    longint ma, mb, qm, v;
    int     pa, pb, s, sh;
    if (b == 0) begin
      r.q = '1;
      r.dbz = 1'b1;
      return r;
    end
    norm_model(a, ma, pa);
    norm_model(b, mb, pb);
    qm = (ma * (64'd1 << F)) / mb;
    s  = pa - pb;
    if (s >= 0) begin
      v = qm * (64'd1 << s);
      sh = F;
    end else begin
      v = qm;
      sh = F - s;
    end
`ifdef DRUM_DIV_ROUND_EN
    v = v + (64'd1 << (sh - 1));
`endif
    v = v / (64'd1 << sh);
    r.q = (v > 65535) ? 16'hFFFF : v[W-1:0];
    r.dbz = 1'b0;
    return r;
  endfunction

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    int waited = 0;
    while (bus.in_ready !== 1'b1 && waited < 100) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (waited >= 100) check_eq("in_ready_timeout", 0, 1);
    bus.a = a;
    bus.b = b;
    bus.in_valid = 1'b1;
    sb_q.push_back(model(a, b));
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    $display("accept a=%0d b=%0d", a, b);
  endtask

  task automatic collect(input bit release_out);
    int   lat = 0;
    exp_t e;
    while (bus.out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_eq("latency", lat, LATENCY);
    if (sb_q.size() == 0) begin
      check_eq("scoreboard_empty", 1, 0);
      return;
    end
    e = sb_q.pop_front();
    check_eq("q", bus.q, e.q);
    check_eq("dbz", bus.dbz, e.dbz);
    if (release_out) begin
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      check_eq("in_ready_after_hs", bus.in_ready, 1);
      check_eq("out_valid_after_hs", bus.out_valid, 0);
    end
  endtask

  initial begin
    logic [W-1:0] va [8] = '{16'd45, 16'd100, 16'd65535, 16'd3, 16'd1234, 16'd0, 16'd63, 16'd40000};
    logic [W-1:0] vb [8] = '{16'd6, 16'd7, 16'd1, 16'd50000, 16'd0, 16'd9, 16'd63, 16'd3};
    logic [W-1:0] hold_q;
    logic         hold_dbz;

    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = '0;
    bus.b = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_eq("rst_out_valid", bus.out_valid, 0);
    check_eq("rst_q", bus.q, 0);
    check_eq("rst_dbz", bus.dbz, 0);
    check_eq("rst_in_ready", bus.in_ready, 1);

    for (int i = 0; i < 8; i++) begin
      start_op(va[i], vb[i]);
      collect(1'b1);
    end

    for (int i = 0; i < 6; i++) begin
      start_op(W'($urandom_range(0, 65535)), W'($urandom_range(1, 65535)));
      collect(1'b1);
    end

    // Back-pressure: hold the result while new operands are offered.
    start_op(16'd500, 16'd9);
    collect(1'b0);
    hold_q = bus.q;
    hold_dbz = bus.dbz;
    bus.a = 16'd777;
    bus.b = 16'd3;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check_eq("stall_q", bus.q, hold_q);
      check_eq("stall_dbz", bus.dbz, hold_dbz);
      check_eq("stall_in_ready", bus.in_ready, 0);
      check_eq("stall_out_valid", bus.out_valid, 1);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check_eq("stall_in_ready_after_hs", bus.in_ready, 1);
    check_eq("stall_out_valid_after_hs", bus.out_valid, 0);

    // Reset in the middle of the DIV phase discards the operation.
    start_op(16'd1000, 16'd3);
    void'(sb_q.pop_back());
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_eq("midrst_out_valid", bus.out_valid, 0);
    check_eq("midrst_in_ready", bus.in_ready, 1);
    start_op(16'd45, 16'd6);
    collect(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
